// File: rtl/booth_pkg.sv
// Shared types and radix-4 Booth recoding helpers for the sequential multiplier family.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Digit codes are packed as {neg, two, nonzero}.
    localparam logic [2:0] PP_ZERO = 3'b000;
    localparam logic [2:0] PP_P1   = 3'b001;
    localparam logic [2:0] PP_P2   = 3'b011;
    localparam logic [2:0] PP_M1   = 3'b101;
    localparam logic [2:0] PP_M2   = 3'b111;

    function automatic logic [2:0] booth_digit(input logic [2:0] triplet);
        logic [2:0] code;
        case (triplet)
            3'b001, 3'b010: code = PP_P1;
            3'b011:         code = PP_P2;
            3'b100:         code = PP_M2;
            3'b101, 3'b110: code = PP_M1;
            default:        code = PP_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Combinational radix-4 Booth digit: maps a multiplier triplet to a WIDTH+2-bit partial product.
module booth_r4_recode #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH+1:0] a_ext,
    output logic [WIDTH+1:0] pp
);
    import booth_pkg::*;

    logic [2:0]       code;
    logic [WIDTH+1:0] mag;

    // Negation at WIDTH+2 bits leaves headroom for -2 * (most negative A).
    always_comb begin
        code = booth_digit(triplet);
        mag  = code[1] ? {a_ext[WIDTH:0], 1'b0} : a_ext;
        if (!code[0]) begin
            pp = '0;
        end else if (code[2]) begin
            pp = ~mag + {{(WIDTH+1){1'b0}}, 1'b1};
        end else begin
            pp = mag;
        end
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: one recoded digit of B retired per clock, start/busy/done handshake.
module booth_mult_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);
    import booth_pkg::*;

    localparam int unsigned NDIG = WIDTH / 2 + 1;
    localparam int unsigned XW   = WIDTH + 2;
    localparam int unsigned AW   = 2 * WIDTH + 2;
    localparam int unsigned KW   = $clog2(NDIG);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("booth_mult_seq: WIDTH must be even and >= 4");
    end

    state_t state, state_next;
    logic   accept;

    logic [XW-1:0]      a_ext;
    logic [XW:0]        bx;          // extended B with the implicit 0 below bit 0
    logic [AW-1:0]      acc;
    logic [KW-1:0]      k;
    logic [2*WIDTH-1:0] result_q;

    logic [KW:0]        idx;
    logic [2:0]         triplet;
    logic [XW-1:0]      pp;
    logic [AW-1:0]      pp_shifted;
    logic [AW-1:0]      acc_next;
    logic               last;

    assign idx        = {k, 1'b0};
    assign triplet    = bx[idx +: 3];
    assign pp_shifted = {{WIDTH{pp[XW-1]}}, pp} << idx;
    assign acc_next   = acc + pp_shifted;
    assign last       = (k == KW'(NDIG - 1));

    booth_r4_recode #(
        .WIDTH (WIDTH)
    ) u_recode (
        .triplet (triplet),
        .a_ext   (a_ext),
        .pp      (pp)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_ext    <= '0;
            bx       <= '0;
            acc      <= '0;
            k        <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_ext <= signed_mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
                bx    <= signed_mode ? {{2{B[WIDTH-1]}}, B, 1'b0} : {2'b00, B, 1'b0};
                acc   <= '0;
                k     <= '0;
            end else if (state == RUN) begin
                acc <= acc_next;
                k   <= k + KW'(1);
                if (last) result_q <= acc_next[2*WIDTH-1:0];
            end
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomised checks of booth_mult_seq at WIDTH=32 against hand values and a reference product.
module tb_booth_mult_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input logic sm, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sm) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Operands are scrambled right after accept to show only latched values matter.
    task automatic launch(input logic sm, input logic [31:0] a, input logic [31:0] b);
        signed_mode = sm;
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = ~a;
        B = b ^ 32'h5A5A_A5A5;
        signed_mode = ~sm;
    endtask

    task automatic wait_done(input int poke_at, output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            if (cycles == poke_at) begin
                start = 1'b1;
                A = 32'h0000_1234;
                B = 32'h0000_5678;
            end else begin
                start = 1'b0;
            end
            tick();
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic sm, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int poke_at);
        int cyc;
        launch(sm, a, b);
        check({tag, "/busy"}, busy, 1);
        check({tag, "/done_low"}, done, 0);
        wait_done(poke_at, cyc);
        check({tag, "/latency"}, cyc, 17);
        check({tag, "/busy_at_done"}, busy, 0);
        check({tag, "/result"}, result, exp);
        tick();
        check({tag, "/done_pulse"}, done, 0);
        check({tag, "/held"}, result, exp);
    endtask

    initial begin
        int cyc;
        int pulses;
        int last_done;
        int dones;
        logic [63:0] q[$];
        logic [31:0] corner[6];
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        A = '0;
        B = '0;
        repeat (2) tick();
        check("reset/busy", busy, 0);
        check("reset/done", done, 0);
        check("reset/result", result, 64'h0);
        reset = 1'b0;
        tick();
        check("idle/busy", busy, 0);

        do_op("s_m1_m1",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, -1);
        do_op("s_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1);
        do_op("u_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1);
        do_op("s_min_1",   1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, -1);
        do_op("u_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
        do_op("s_7_m3",    1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, -1);
        do_op("u_x2",      1'b0, 32'h1234_5678, 32'h0000_0002, 64'h0000_0000_2468_ACF0, -1);
        do_op("s_m1_max",  1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001, -1);
        do_op("u_zero",    1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 64'h0, -1);

        // start during RUN must be ignored
        do_op("ignore_start", 1'b0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 5);
        check("ignore_start/idle", busy, 0);

        // reset mid-run aborts with no done
        launch(1'b0, 32'h0000_0005, 32'h0000_0006);
        repeat (8) tick();
        reset = 1'b1;
        tick();
        check("abort/busy", busy, 0);
        check("abort/done", done, 0);
        check("abort/result", result, 64'h0);
        reset = 1'b0;
        pulses = 0;
        repeat (30) begin
            tick();
            if (done) pulses++;
        end
        check("abort/no_done", pulses, 0);
        do_op("after_abort", 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, -1);

        // start held high, operands changing every cycle
        last_done = -1;
        dones = 0;
        start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            A = 32'h9E37_79B9 * (c + 1);
            B = 32'h7F4A_7C15 ^ (c * 32'h0101_0101);
            signed_mode = c[0];
            if (!busy) q.push_back(ref_mul(signed_mode, A, B));
            tick();
            if (done) begin
                if (q.size() == 0) check("b2b/queue", 1, 0);
                else check("b2b/result", result, q.pop_front());
                if (last_done >= 0) check("b2b/period", c - last_done, 18);
                last_done = c;
                dones++;
            end
        end
        check("b2b/dones", dones, 3);
        wait_done(-1, cyc);
        check("b2b/last_done", done, 1);
        if (q.size() == 0) check("b2b/last_queue", 1, 0);
        else check("b2b/last_result", result, q.pop_front());
        check("b2b/drained", q.size(), 0);
        tick();

        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        corner[5] = 32'hAAAA_AAAA;
        for (int i = 0; i < 2000; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            launch(rs, ra, rb);
            wait_done(-1, cyc);
            check("rand/latency", cyc, 17);
            check("rand/result", result, ref_mul(rs, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
